// File: rtl/hash_partitioner_pkg.sv
// Shared defaults, FSM state encoding and the line record for the hash partitioner.
// Optional statistics counters are enabled with the PARTITIONER_STATS_EN macro.
package hash_partitioner_pkg;

  localparam int DEF_PART_BITS       = 4;
  localparam int DEF_TUPLES_PER_LINE = 8;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    FLUSH  = 2'd1,
    TERM   = 2'd2
  } part_state_e;

  typedef struct packed {
    logic [64*DEF_TUPLES_PER_LINE-1:0]     data;
    logic [DEF_PART_BITS-1:0]              part;
    logic [$clog2(DEF_TUPLES_PER_LINE):0]  count;
    logic                                  last;
    logic [63:0]                           serialnum;
  } part_line_t;

endpackage

// File: rtl/hash_partitioner_if.sv
// Tuple input stream and packed-line output stream of one partitioner lane.
interface hash_partitioner_if #(
  parameter int PART_BITS       = 4,
  parameter int TUPLES_PER_LINE = 8
);
  localparam int CW = $clog2(TUPLES_PER_LINE) + 1;

  logic                            in_ready;
  logic                            in_valid;
  logic [63:0]                     in_tuple;
  logic [31:0]                     in_tag;
  logic                            in_last_processed;
  logic [63:0]                     in_serialnum;
  logic                            out_ready;
  logic                            out_valid;
  logic [64*TUPLES_PER_LINE-1:0]   out_data;
  logic [PART_BITS-1:0]            out_part;
  logic [CW-1:0]                   out_count;
  logic                            out_last;
  logic [63:0]                     out_serialnum;

  modport master (
    output in_valid, in_tuple, in_tag, in_last_processed, in_serialnum, out_ready,
    input  in_ready, out_valid, out_data, out_part, out_count, out_last, out_serialnum
  );

  modport slave (
    input  in_valid, in_tuple, in_tag, in_last_processed, in_serialnum, out_ready,
    output in_ready, out_valid, out_data, out_part, out_count, out_last, out_serialnum
  );

endinterface

// File: rtl/hash_partitioner_line_buf.sv
// Per-partition tuple slots, fill counters and last-written serial numbers.
// The read port returns a whole line with slots at or beyond the fill level forced to zero.
module partition_line_buf #(
  parameter int PART_BITS       = 4,
  parameter int TUPLES_PER_LINE = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [PART_BITS-1:0]           wr_part,
  input  logic [63:0]                    wr_tuple,
  input  logic [63:0]                    wr_serial,
  input  logic                           clr_en,
  input  logic [PART_BITS-1:0]           clr_part,
  input  logic [PART_BITS-1:0]           rd_part,
  output logic [64*TUPLES_PER_LINE-1:0]  rd_data,
  output logic [$clog2(TUPLES_PER_LINE)-1:0] rd_fill,
  output logic [63:0]                    rd_serial
);

  localparam int NPART = 1 << PART_BITS;
  localparam int FW    = $clog2(TUPLES_PER_LINE);

  logic [63:0]   slot_r   [NPART][TUPLES_PER_LINE];
  logic [FW-1:0] fill_r   [NPART];
  logic [63:0]   serial_r [NPART];

  // Slot storage needs no reset: stale slots are masked by the fill level on read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      slot_r[wr_part][fill_r[wr_part]] <= wr_tuple;
    end
  end

  // Fill counters wrap to zero when a line completes, so a full line clears itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NPART; p++) begin
        fill_r[p]   <= '0;
        serial_r[p] <= 64'd0;
      end
    end else begin
      if (wr_en) begin
        fill_r[wr_part]   <= fill_r[wr_part] + FW'(1);
        serial_r[wr_part] <= wr_serial;
      end
      if (clr_en) begin
        fill_r[clr_part] <= '0;
      end
    end
  end

  // Whole-line read of the selected partition.
  always_comb begin
    rd_fill   = fill_r[rd_part];
    rd_serial = serial_r[rd_part];
    rd_data   = '0;
    for (int k = 0; k < TUPLES_PER_LINE; k++) begin
      if (FW'(k) < fill_r[rd_part]) begin
        rd_data[64*k +: 64] = slot_r[rd_part][k];
      end else begin
        rd_data[64*k +: 64] = 64'd0;
      end
    end
  end

endmodule

// File: rtl/hash_partitioner.sv
// Single-lane radix partitioner: packs hashed tuples into per-partition lines, flushes on end of stream.
// Define PARTITIONER_STATS_EN to add the stat_tuples / stat_lines counters.
module hash_partitioner
  import hash_partitioner_pkg::*;
#(
  parameter int PART_BITS       = DEF_PART_BITS,
  parameter int TUPLES_PER_LINE = DEF_TUPLES_PER_LINE
) (
  input  logic               clk,
  input  logic               reset,
  hash_partitioner_if.slave  bus
`ifdef PARTITIONER_STATS_EN
  ,
  output logic [63:0]        stat_tuples,
  output logic [63:0]        stat_lines
`endif
);

  localparam int NPART = 1 << PART_BITS;
  localparam int FW    = $clog2(TUPLES_PER_LINE);
  localparam int CW    = FW + 1;
  localparam int LW    = 64 * TUPLES_PER_LINE;
  localparam logic [FW-1:0]        FILL_MAX   = FW'(TUPLES_PER_LINE - 1);
  localparam logic [CW-1:0]        COUNT_FULL = CW'(TUPLES_PER_LINE);
  localparam logic [PART_BITS-1:0] PART_LAST  = PART_BITS'(NPART - 1);

  part_state_e          state_r;
  logic [PART_BITS-1:0] scan_r;
  logic [63:0]          final_serial_r;
  logic                 out_valid_r;
  logic [LW-1:0]        out_data_r;
  logic [PART_BITS-1:0] out_part_r;
  logic [CW-1:0]        out_count_r;
  logic                 out_last_r;
  logic [63:0]          out_serial_r;

  logic                 out_free_s;
  logic                 in_ready_s;
  logic                 acc_s;
  logic                 complete_s;
  logic                 flush_load_s;
  logic                 flush_step_s;
  logic [PART_BITS-1:0] in_part_s;
  logic [PART_BITS-1:0] rd_part_s;
  logic [LW-1:0]        rd_data_s;
  logic [FW-1:0]        rd_fill_s;
  logic [63:0]          rd_serial_s;
  logic [LW-1:0]        full_line_s;

  // Handshake and per-cycle load decisions; upper tag bits never reach the partition id.
  always_comb begin
    in_part_s    = bus.in_tag[PART_BITS-1:0];
    out_free_s   = !out_valid_r || bus.out_ready;
    in_ready_s   = !reset && (state_r == ACCEPT) && out_free_s;
    acc_s        = bus.in_valid && in_ready_s;
    rd_part_s    = (state_r == FLUSH) ? scan_r : in_part_s;
    complete_s   = acc_s && (rd_fill_s == FILL_MAX);
    flush_load_s = (state_r == FLUSH) && (rd_fill_s != '0) && out_free_s;
    flush_step_s = (state_r == FLUSH) && ((rd_fill_s == '0) || out_free_s);
    full_line_s  = rd_data_s;
    full_line_s[LW-1 -: 64] = bus.in_tuple;
  end

  partition_line_buf #(
    .PART_BITS       (PART_BITS),
    .TUPLES_PER_LINE (TUPLES_PER_LINE)
  ) u_line_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (acc_s),
    .wr_part   (in_part_s),
    .wr_tuple  (bus.in_tuple),
    .wr_serial (bus.in_serialnum),
    .clr_en    (flush_load_s),
    .clr_part  (scan_r),
    .rd_part   (rd_part_s),
    .rd_data   (rd_data_s),
    .rd_fill   (rd_fill_s),
    .rd_serial (rd_serial_s)
  );

  // Control FSM and the single output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ACCEPT;
      scan_r         <= '0;
      final_serial_r <= 64'd0;
      out_valid_r    <= 1'b0;
      out_data_r     <= '0;
      out_part_r     <= '0;
      out_count_r    <= '0;
      out_last_r     <= 1'b0;
      out_serial_r   <= 64'd0;
    end else begin
      if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        ACCEPT: begin
          if (complete_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= full_line_s;
            out_part_r   <= in_part_s;
            out_count_r  <= COUNT_FULL;
            out_last_r   <= 1'b0;
            out_serial_r <= bus.in_serialnum;
          end
          if (acc_s && bus.in_last_processed) begin
            state_r        <= FLUSH;
            scan_r         <= '0;
            final_serial_r <= bus.in_serialnum;
          end
        end
        FLUSH: begin
          if (flush_load_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= rd_data_s;
            out_part_r   <= scan_r;
            out_count_r  <= {1'b0, rd_fill_s};
            out_last_r   <= 1'b0;
            out_serial_r <= rd_serial_s;
          end
          if (flush_step_s) begin
            if (scan_r == PART_LAST) begin
              state_r <= TERM;
            end else begin
              scan_r <= scan_r + PART_BITS'(1);
            end
          end
        end
        TERM: begin
          if (out_free_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= '0;
            out_part_r   <= '0;
            out_count_r  <= '0;
            out_last_r   <= 1'b1;
            out_serial_r <= final_serial_r;
            state_r      <= ACCEPT;
          end
        end
        default: begin
          state_r <= ACCEPT;
        end
      endcase
    end
  end

`ifdef PARTITIONER_STATS_EN
  logic [63:0] stat_tuples_r;
  logic [63:0] stat_lines_r;

  // Free-running accepted-tuple and data-line counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_tuples_r <= 64'd0;
      stat_lines_r  <= 64'd0;
    end else begin
      if (acc_s) begin
        stat_tuples_r <= stat_tuples_r + 64'd1;
      end
      if (complete_s || flush_load_s) begin
        stat_lines_r <= stat_lines_r + 64'd1;
      end
    end
  end

  assign stat_tuples = stat_tuples_r;
  assign stat_lines  = stat_lines_r;
`endif

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_data      = out_data_r;
  assign bus.out_part      = out_part_r;
  assign bus.out_count     = out_count_r;
  assign bus.out_last      = out_last_r;
  assign bus.out_serialnum = out_serial_r;

endmodule

// File: tb/tb_hash_partitioner.sv
// Scoreboard bench for hash_partitioner: a per-partition list model predicts every output line.
module tb_hash_partitioner;
  import hash_partitioner_pkg::*;

  localparam int PB = DEF_PART_BITS;
  localparam int T  = DEF_TUPLES_PER_LINE;
  localparam int NP = 1 << PB;
  localparam int CW = $clog2(T) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  hash_partitioner_if #(.PART_BITS(PB), .TUPLES_PER_LINE(T)) bus ();

`ifdef PARTITIONER_STATS_EN
  logic [63:0] stat_tuples;
  logic [63:0] stat_lines;
`endif

  hash_partitioner #(.PART_BITS(PB), .TUPLES_PER_LINE(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PARTITIONER_STATS_EN
    ,
    .stat_tuples (stat_tuples),
    .stat_lines  (stat_lines)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ready_mode = 1;
  logic [63:0] serial_ctr = 64'd100;

  part_line_t  exp_q[$];
  logic [63:0] pbuf [NP][T];
  int          pcnt [NP];
  logic [63:0] pser [NP];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push_part_line(int p);
    part_line_t l;
    l.data = '0;
    for (int k = 0; k < pcnt[p]; k++) l.data[64*k +: 64] = pbuf[p][k];
    l.part      = PB'(p);
    l.count     = CW'(pcnt[p]);
    l.last      = 1'b0;
    l.serialnum = pser[p];
    exp_q.push_back(l);
    pcnt[p] = 0;
  endfunction

  // Reference: append to the partition's list; a full list becomes a line; last flushes all then terminates.
  function automatic void model_accept(logic [63:0] tuple, logic [31:0] tag, bit last, logic [63:0] ser);
    int p;
    part_line_t t;
    p = int'(tag % NP);
    pbuf[p][pcnt[p]] = tuple;
    pcnt[p]++;
    pser[p] = ser;
    if (pcnt[p] == T) push_part_line(p);
    if (last) begin
      for (int q = 0; q < NP; q++) if (pcnt[q] > 0) push_part_line(q);
      t.data = '0; t.part = '0; t.count = '0; t.last = 1'b1; t.serialnum = ser;
      exp_q.push_back(t);
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    for (int p = 0; p < NP; p++) pcnt[p] = 0;
  endfunction

  task automatic set_ready(input int m);
    ready_mode = m;
    if (m < 2) bus.out_ready = (m == 1);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode == 0)      bus.out_ready = 1'b0;
      else if (ready_mode == 1) bus.out_ready = 1'b1;
      else                      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [31:0] tag, input bit last);
    bit done;
    done = 1'b0;
    bus.in_valid          = 1'b1;
    bus.in_tuple          = {$urandom, $urandom};
    bus.in_tag            = tag;
    bus.in_last_processed = last;
    bus.in_serialnum      = serial_ctr;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_accept(bus.in_tuple, tag, last, serial_ctr);
        done = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted tag=%0h", tag);
    end
    serial_ctr = serial_ctr + 64'd1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    model_clear();
    @(negedge clk);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_last", 64'(bus.out_last), 64'd0);
    chk("reset_out_count", 64'(bus.out_count), 64'd0);
    chk("reset_out_part", 64'(bus.out_part), 64'd0);
    chk("reset_out_serial", bus.out_serialnum, 64'd0);
    chk("reset_out_data_or", 64'(|bus.out_data), 64'd0);
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks hold stability under backpressure.
  logic [64*T-1:0] prev_data;
  logic [PB-1:0]   prev_part;
  logic [CW-1:0]   prev_count;
  logic            prev_last;
  logic [63:0]     prev_serial;
  bit              prev_hold = 1'b0;

  initial begin
    part_line_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          checks++;
          if (!bus.out_valid || bus.out_data !== prev_data || bus.out_part !== prev_part ||
              bus.out_count !== prev_count || bus.out_last !== prev_last || bus.out_serialnum !== prev_serial) begin
            failures++;
            $display("FAIL hold_stable actual valid=%0b part=%0d count=%0d required part=%0d count=%0d held",
                     bus.out_valid, bus.out_part, bus.out_count, prev_part, prev_count);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_line actual part=%0d count=%0d last=%0b required=none",
                     bus.out_part, bus.out_count, bus.out_last);
          end else begin
            e = exp_q.pop_front();
            if (bus.out_data !== e.data || bus.out_part !== e.part || bus.out_count !== e.count ||
                bus.out_last !== e.last || bus.out_serialnum !== e.serialnum) begin
              failures++;
              $display("FAIL line actual part=%0d count=%0d last=%0b serial=%0h data=%0h required part=%0d count=%0d last=%0b serial=%0h data=%0h",
                       bus.out_part, bus.out_count, bus.out_last, bus.out_serialnum, bus.out_data,
                       e.part, e.count, e.last, e.serialnum, e.data);
            end
          end
        end
        prev_hold   = bus.out_valid && !bus.out_ready;
        prev_data   = bus.out_data;
        prev_part   = bus.out_part;
        prev_count  = bus.out_count;
        prev_last   = bus.out_last;
        prev_serial = bus.out_serialnum;
      end
    end
  end

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_tuple = 64'd0;
    bus.in_tag = 32'd0;
    bus.in_last_processed = 1'b0;
    bus.in_serialnum = 64'd0;
    model_clear();
    do_reset();

    // 1: one full line to partition 3, one-cycle latency
    set_ready(1);
    for (int i = 0; i < T; i++) begin
      send(32'h13, 1'b0);
      if (i == T - 2) chk("t1_no_early_valid", 64'(bus.out_valid), 64'd0);
    end
    chk("t1_latency_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_part", 64'(bus.out_part), 64'd3);
    chk("t1_count", 64'(bus.out_count), 64'(T));
    drain();

    // 2: partial lines flushed in partition order, then terminator; upper tag bits ignored
    send(32'h0, 1'b0);
    send(32'hABCD_0100, 1'b0);
    send(32'h5, 1'b1);
    drain();

    // 3: backpressure on a pending full line
    set_ready(0);
    for (int i = 0; i < T; i++) send(32'h2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_in_ready_blocked", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    set_ready(1);
    for (int i = 0; i < T; i++) send(32'h2, 1'b0);
    drain();

    // 4: last tuple completes partition 7; full scan then terminator
    for (int i = 0; i < T - 1; i++) send(32'h7, 1'b0);
    send(32'h7, 1'b1);
    drain();
    @(negedge clk);
    chk("t4_in_ready_after_term", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // 5: reset in the middle of a stalled flush
    set_ready(0);
    send(32'h1, 1'b0); send(32'h1, 1'b0);
    send(32'h4, 1'b0); send(32'h4, 1'b0);
    send(32'h9, 1'b0); send(32'h9, 1'b0);
    send(32'hC, 1'b0); send(32'hC, 1'b1);
    for (int i = 0; i < 6; i++) @(posedge clk);
    #1;
    do_reset();
    set_ready(1);
    @(negedge clk);
    chk("t5_in_ready_after_reset", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < T; i++) send(32'h1, i == T - 1);
    drain();

`ifdef PARTITIONER_STATS_EN
    // 6: statistics counters
    do_reset();
    set_ready(2);
    for (int i = 0; i < 20; i++) send(32'h2, i == 19);
    drain();
    chk("t6_stat_tuples", stat_tuples, 64'd20);
    chk("t6_stat_lines", stat_lines, 64'd3);
`endif

    // Randomised streams with random backpressure, idle gaps and full 32-bit tags
    set_ready(2);
    for (int s = 0; s < 3; s++) begin
      n = int'($urandom_range(20, 90));
      for (int i = 0; i < n; i++) begin
        send($urandom, i == n - 1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      drain();
    end

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
